writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Parametrised writeback (WB) stage of the pipelined datapath; successor to the fixed 16-bit WB stage.
- Accepts one result per transaction from the memory stage over a valid/ready handshake, evaluates conditional execution against a held condition flag, and writes the register file through a write/acknowledge port.
- Exposes the FSM state on ESTADO for bench monitoring and counts retired instructions.

Parameters:
DATA_W, 16, result/register data width
REG_AW, 5, register address width
OPCD_W, 5, opcode width
CNT_W, 16, retired-instruction counter width
OP_NOP, 0, opcode that retires with no effect
OP_CMP, 10, opcode that updates COND, no register write
ZERO_REG, 1, 1 = writes to register 0 are suppressed

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
IN_VALID  in  1  memory-stage result valid
IN_READY  out  1  stage can accept
DATA_IN  in  DATA_W  result data
OPCD_IN  in  OPCD_W  opcode
ADDR_REG_IN  in  REG_AW  destination register
OPT_BIT_IN  in  1  1 = conditional: write only if COND=1
WR_EN  out  1  register-file write request
WR_ACK  in  1  register-file write accepted
DATA_OUT  out  DATA_W  write data
ADDR_REG_OUT  out  REG_AW  write address
COND  out  1  condition flag
ESTADO  out  3  FSM state
RETIRE  out  1  one-cycle pulse per retired instruction
RETIRE_CNT  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, RST=1): ESTADO=IDLE; IN_READY=0 while RST=1, 1 in the first cycle after release. WR_EN=0, DATA_OUT=0, ADDR_REG_OUT=0, COND=0, RETIRE=0, RETIRE_CNT=0. Reset mid-transaction aborts it; no write or retire occurs.
- States (ESTADO encoding): IDLE=0, EVAL=1, WRITE=2, DONE=3; codes 4-7 are unused and map to IDLE.
- IDLE: IN_READY=1. On a rising edge with IN_VALID=1, latch DATA_IN, OPCD_IN, ADDR_REG_IN and OPT_BIT_IN, then go to EVAL. IN_READY=0 in every other state.
- EVAL, 1 cycle; evaluation uses the COND value held before this instruction:
  - OPCD=OP_NOP -> DONE.
  - OPCD=OP_CMP -> COND <= (data != 0) at the EVAL edge -> DONE.
  - OPT_BIT=1 and COND=0 -> DONE (squashed).
  - ZERO_REG=1 and addr=0 -> DONE.
  - Otherwise drive DATA_OUT/ADDR_REG_OUT -> WRITE.
- WRITE: WR_EN=1; DATA_OUT and ADDR_REG_OUT are held stable. On the edge with WR_ACK=1 -> DONE. WR_ACK sampled outside WRITE is ignored. There is no timeout.
- DONE: RETIRE=1 for exactly 1 cycle; RETIRE_CNT += 1, wrapping modulo 2^CNT_W; next state IDLE. Squashed, NOP and CMP instructions also retire.
- Latency: accept edge N; WR_EN high from N+1; with WR_ACK already high, DONE at N+2 and IN_READY=1 again at N+3. Throughput is 1 instruction per 4 cycles minimum (3 when no write occurs).
- DATA_OUT and ADDR_REG_OUT keep their last written value outside WRITE.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: adds outputs BYP_VALID (1), BYP_ADDR (REG_AW) and BYP_DATA (DATA_W). BYP_VALID=1 in the EVAL cycle that proceeds to WRITE and throughout WRITE; it carries the pending address and data so decode can forward them. All three reset to 0.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold RST=1 for 2 cycles, then 0 -> all outputs 0, ESTADO=0, IN_READY=1 in the first cycle after release.
- Plain write: DATA_IN=16'h1234, ADDR_REG_IN=7, OPCD_IN=3, OPT_BIT_IN=0, WR_ACK tied 1 -> WR_EN high 1 cycle with DATA_OUT=16'h1234 and ADDR_REG_OUT=7; RETIRE pulse; RETIRE_CNT=1; ESTADO sequence 0,1,2,3,0.
- Conditional: send CMP with data 0, then a conditional write to reg 4 -> no WR_EN. Send CMP with data 5, then the same write -> WR_EN with addr 4, COND=1. RETIRE_CNT=4.
- Stall: WR_ACK=0 for 5 cycles, then 1 -> WR_EN held 6 cycles with stable data, IN_READY=0 throughout, exactly one RETIRE.
- Reg-0 and NOP: a write to addr 0 and one OP_NOP -> no WR_EN, two RETIRE pulses. Counter wrap with CNT_W=2: 5 instructions -> RETIRE_CNT=1.
- Reset mid-WRITE: assert RST while WR_EN=1 -> WR_EN drops immediately (asynchronously), RETIRE_CNT unchanged from 0, ESTADO=0.

Source files
------------

// File: rtl/writeback_stage.sv
// writeback_stage -- parametrised writeback stage of the pipelined datapath.
//
// Accepts one result per transaction from the memory stage (IN_VALID/IN_READY),
// evaluates conditional execution against the held COND flag, writes the
// register file over a WR_EN/WR_ACK port and counts retired instructions.
//
// Ports:
//   CLK, RST (async, active-high)
//   IN_VALID, IN_READY, DATA_IN, OPCD_IN, ADDR_REG_IN, OPT_BIT_IN  -- input transaction
//   WR_EN, WR_ACK, DATA_OUT, ADDR_REG_OUT                           -- register-file write port
//   COND                                                            -- condition flag
//   ESTADO                                                          -- FSM state (monitor)
//   RETIRE, RETIRE_CNT                                              -- retire pulse / count
//   BYP_VALID, BYP_ADDR, BYP_DATA                                   -- forwarding (WB_BYPASS_EN only)
//
// Optional feature: define WB_BYPASS_EN to add the forwarding outputs.
//
// state | meaning
// IDLE  | waiting for a result, IN_READY=1
// EVAL  | decide write / squash / CMP / NOP using the COND held before this op
// WRITE | WR_EN=1 until WR_ACK
// DONE  | one-cycle retire pulse
module writeback_stage #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 5,
    parameter int OPCD_W   = 5,
    parameter int CNT_W    = 16,
    parameter int OP_NOP   = 0,
    parameter int OP_CMP   = 10,
    parameter int ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic [OPCD_W-1:0] OPCD_IN,
    input  logic [REG_AW-1:0] ADDR_REG_IN,
    input  logic              OPT_BIT_IN,
    output logic              WR_EN,
    input  logic              WR_ACK,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic [REG_AW-1:0] ADDR_REG_OUT,
    output logic              COND,
    output logic [2:0]        ESTADO,
    output logic              RETIRE,
    output logic [CNT_W-1:0]  RETIRE_CNT
`ifdef WB_BYPASS_EN
    ,
    output logic              BYP_VALID,
    output logic [REG_AW-1:0] BYP_ADDR,
    output logic [DATA_W-1:0] BYP_DATA
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EVAL  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3
    } state_t;

    localparam logic [OPCD_W-1:0] NOP_CODE = OPCD_W'(OP_NOP);
    localparam logic [OPCD_W-1:0] CMP_CODE = OPCD_W'(OP_CMP);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [OPCD_W-1:0]   opcd_q, opcd_d;
    logic [REG_AW-1:0]   addr_q, addr_d;
    logic                opt_q, opt_d;
    logic                cond_q, cond_d;
    logic                wr_en_q, wr_en_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic [REG_AW-1:0]   addr_out_q, addr_out_d;
    logic                retire_q, retire_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                eval_write;

    // Only an ordinary, unsquashed op to a writable register reaches WRITE.
    assign eval_write = (opcd_q != NOP_CODE) && (opcd_q != CMP_CODE) &&
                        !(opt_q && !cond_q) &&
                        !((ZERO_REG != 0) && (addr_q == '0));

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        opcd_d     = opcd_q;
        addr_d     = addr_q;
        opt_d      = opt_q;
        cond_d     = cond_q;
        wr_en_d    = wr_en_q;
        data_out_d = data_out_q;
        addr_out_d = addr_out_q;
        retire_d   = 1'b0;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (IN_VALID) begin
                    data_d  = DATA_IN;
                    opcd_d  = OPCD_IN;
                    addr_d  = ADDR_REG_IN;
                    opt_d   = OPT_BIT_IN;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                if (opcd_q == CMP_CODE) begin
                    cond_d = (data_q != '0);
                end
                if (eval_write) begin
                    data_out_d = data_q;
                    addr_out_d = addr_q;
                    wr_en_d    = 1'b1;
                    state_d    = S_WRITE;
                end else begin
                    retire_d = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    state_d  = S_DONE;
                end
            end
            S_WRITE: begin
                if (WR_ACK) begin
                    wr_en_d  = 1'b0;
                    retire_d = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                wr_en_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            opcd_q     <= '0;
            addr_q     <= '0;
            opt_q      <= 1'b0;
            cond_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            data_out_q <= '0;
            addr_out_q <= '0;
            retire_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            opcd_q     <= opcd_d;
            addr_q     <= addr_d;
            opt_q      <= opt_d;
            cond_q     <= cond_d;
            wr_en_q    <= wr_en_d;
            data_out_q <= data_out_d;
            addr_out_q <= addr_out_d;
            retire_q   <= retire_d;
            cnt_q      <= cnt_d;
        end
    end

    // Ready is held low for the whole reset and rises as soon as it releases.
    assign IN_READY     = (state_q == S_IDLE) && !RST;
    assign WR_EN        = wr_en_q;
    assign DATA_OUT     = data_out_q;
    assign ADDR_REG_OUT = addr_out_q;
    assign COND         = cond_q;
    assign ESTADO       = state_q;
    assign RETIRE       = retire_q;
    assign RETIRE_CNT   = cnt_q;

`ifdef WB_BYPASS_EN
    // Forwarding is visible one cycle early, in the EVAL cycle that commits to a write.
    assign BYP_VALID = ((state_q == S_EVAL) && eval_write) || (state_q == S_WRITE);
    assign BYP_ADDR  = BYP_VALID ? addr_q : '0;
    assign BYP_DATA  = BYP_VALID ? data_q : '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] data_in;
    logic [4:0]  opcd_in;
    logic [4:0]  addr_in;
    logic        opt_bit;
    logic        wr_ack;

    logic        in_ready, wr_en, cond, retire;
    logic [15:0] data_out;
    logic [4:0]  addr_out;
    logic [2:0]  estado;
    logic [15:0] retire_cnt;

    logic        in_ready2, wr_en2, cond2, retire2;
    logic [15:0] data_out2;
    logic [4:0]  addr_out2;
    logic [2:0]  estado2;
    logic [1:0]  retire_cnt2;

`ifdef WB_BYPASS_EN
    logic        byp_valid, byp_valid2;
    logic [4:0]  byp_addr, byp_addr2;
    logic [15:0] byp_data, byp_data2;
`endif

    always #5 clk = ~clk;

    writeback_stage u_dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
        .DATA_IN(data_in), .OPCD_IN(opcd_in), .ADDR_REG_IN(addr_in), .OPT_BIT_IN(opt_bit),
        .WR_EN(wr_en), .WR_ACK(wr_ack), .DATA_OUT(data_out), .ADDR_REG_OUT(addr_out),
        .COND(cond), .ESTADO(estado), .RETIRE(retire), .RETIRE_CNT(retire_cnt)
`ifdef WB_BYPASS_EN
        , .BYP_VALID(byp_valid), .BYP_ADDR(byp_addr), .BYP_DATA(byp_data)
`endif
    );

    // Same stimulus, 2-bit counter, to exercise wrap-around.
    writeback_stage #(.CNT_W(2)) u_dut_c2 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready2),
        .DATA_IN(data_in), .OPCD_IN(opcd_in), .ADDR_REG_IN(addr_in), .OPT_BIT_IN(opt_bit),
        .WR_EN(wr_en2), .WR_ACK(wr_ack), .DATA_OUT(data_out2), .ADDR_REG_OUT(addr_out2),
        .COND(cond2), .ESTADO(estado2), .RETIRE(retire2), .RETIRE_CNT(retire_cnt2)
`ifdef WB_BYPASS_EN
        , .BYP_VALID(byp_valid2), .BYP_ADDR(byp_addr2), .BYP_DATA(byp_data2)
`endif
    );

    int errors = 0;
    int checks = 0;

    // reference model state
    int          m_cnt;
    bit          m_cond;
    logic [15:0] m_dout;
    logic [4:0]  m_aout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_cond = 1'b0;
        m_dout = '0;
        m_aout = '0;
    endtask

    // One full transaction, starting and ending at a negedge in IDLE.
    task automatic do_instr(input logic [15:0] d, input logic [4:0] op, input logic [4:0] a,
                            input bit opt, input int stall);
        bit will_write;
        will_write = (op != 5'd0) && (op != 5'd10) && !(opt && !m_cond) && (a != 5'd0);
        chk("idle_ready", 32'(in_ready), 32'd1);
        chk("idle_state", 32'(estado), 32'd0);
        in_valid = 1'b1; data_in = d; opcd_in = op; addr_in = a; opt_bit = opt;
        wr_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        in_valid = 1'b0;
        data_in  = 16'($urandom);
        opcd_in  = 5'($urandom);
        addr_in  = 5'($urandom);
        opt_bit  = 1'($urandom);
        chk("eval_state", 32'(estado), 32'd1);
        chk("eval_ready", 32'(in_ready), 32'd0);
        chk("eval_wr_en", 32'(wr_en), 32'd0);
`ifdef WB_BYPASS_EN
        chk("eval_byp_valid", 32'(byp_valid), 32'(will_write));
        if (will_write) begin
            chk("eval_byp_addr", 32'(byp_addr), 32'(a));
            chk("eval_byp_data", 32'(byp_data), 32'(d));
        end
`endif
        wr_ack = 1'($urandom_range(0, 1));
        if (op == 5'd10) m_cond = (d != 16'd0);
        if (will_write) begin
            m_dout = d;
            m_aout = a;
            for (int k = 0; k <= stall; k++) begin
                @(negedge clk);
                chk("write_state", 32'(estado), 32'd2);
                chk("write_wr_en", 32'(wr_en), 32'd1);
                chk("write_data", 32'(data_out), 32'(d));
                chk("write_addr", 32'(addr_out), 32'(a));
                chk("write_ready", 32'(in_ready), 32'd0);
                chk("write_retire", 32'(retire), 32'd0);
                chk("write_cond", 32'(cond), 32'(m_cond));
                wr_ack = (k >= stall);
            end
        end
        @(negedge clk);
        m_cnt++;
        chk("done_state", 32'(estado), 32'd3);
        chk("done_retire", 32'(retire), 32'd1);
        chk("done_wr_en", 32'(wr_en), 32'd0);
        chk("done_ready", 32'(in_ready), 32'd0);
        chk("done_cnt", 32'(retire_cnt), 32'(m_cnt % 65536));
        chk("done_cnt_wrap", 32'(retire_cnt2), 32'(m_cnt % 4));
        chk("done_state_c2", 32'(estado2), 32'd3);
        chk("done_cond", 32'(cond), 32'(m_cond));
        chk("hold_data", 32'(data_out), 32'(m_dout));
        chk("hold_addr", 32'(addr_out), 32'(m_aout));
        wr_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("after_state", 32'(estado), 32'd0);
        chk("after_retire", 32'(retire), 32'd0);
        chk("after_ready", 32'(in_ready), 32'd1);
        chk("after_cnt", 32'(retire_cnt), 32'(m_cnt % 65536));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; data_in = '0; opcd_in = '0; addr_in = '0;
        opt_bit = 1'b0; wr_ack = 1'b0;
        model_reset();

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_state", 32'(estado), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_ready", 32'(in_ready), 32'd1);
        chk("rel_wr_en", 32'(wr_en), 32'd0);
        chk("rel_data", 32'(data_out), 32'd0);
        chk("rel_addr", 32'(addr_out), 32'd0);
        chk("rel_cond", 32'(cond), 32'd0);
        chk("rel_retire", 32'(retire), 32'd0);
        chk("rel_cnt", 32'(retire_cnt), 32'd0);
        @(negedge clk);

        // reset in the middle of WRITE
        in_valid = 1'b1; data_in = 16'hA5A5; opcd_in = 5'd3; addr_in = 5'd9; opt_bit = 1'b0;
        wr_ack = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort_pre_wr_en", 32'(wr_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_wr_en", 32'(wr_en), 32'd0);
        chk("abort_state", 32'(estado), 32'd0);
        chk("abort_cnt", 32'(retire_cnt), 32'd0);
        chk("abort_retire", 32'(retire), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        chk("abort_rel_ready", 32'(in_ready), 32'd1);
        chk("abort_rel_data", 32'(data_out), 32'd0);
        @(negedge clk);

        // plain write
        do_instr(16'h1234, 5'd3, 5'd7, 1'b0, 0);
        // conditional execution
        do_instr(16'h0000, 5'd10, 5'd2, 1'b0, 0);
        do_instr(16'hBEEF, 5'd3, 5'd4, 1'b1, 0);
        do_instr(16'h0005, 5'd10, 5'd2, 1'b0, 0);
        do_instr(16'hBEEF, 5'd3, 5'd4, 1'b1, 0);
        // write stall
        do_instr(16'h5A5A, 5'd6, 5'd12, 1'b0, 5);
        // register 0 and NOP
        do_instr(16'h7777, 5'd3, 5'd0, 1'b0, 0);
        do_instr(16'h8888, 5'd0, 5'd5, 1'b0, 0);

        // randomized traffic
        for (int i = 0; i < 24; i++) begin
            int          sel;
            logic [4:0]  op;
            logic [15:0] d;
            logic [4:0]  a;
            sel = int'($urandom_range(0, 3));
            if (sel == 0)      op = 5'd0;
            else if (sel == 1) op = 5'd10;
            else begin
                op = 5'($urandom_range(1, 31));
                if (op == 5'd10) op = 5'd11;
            end
            d = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            a = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            do_instr(d, op, a, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
